timepulse_monitor: RTL and testbench
====================================

TIMEPULSE_MONITOR -- requirements
Module: timepulse_monitor

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 64, giving the cycles without a timepulse transition before stall is declared.
REQ-002 SHALL have parameter CNT_W, default 16, giving the memory-cycle counter width.
REQ-003 SHALL have port SIM_CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port SIM_RST, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port T_n, input, 12: active-low timepulses; bit i-1 carries T(i)_n, i=1..12.
REQ-006 SHALL have port GOJAM, input, 1: restart in progress, active high.
REQ-007 SHALL have port STOP, input, 1: timer halted, active high.
REQ-008 SHALL have port TP_IDX, output, 4: index 1..12 of the last valid timepulse; 0 when none.
REQ-009 SHALL have port LOCKED, output, 1: high while in state LOCK.
REQ-010 SHALL have port MCT_STB, output, 1: one-cycle pulse on each completed memory cycle (T12 followed by T01).
REQ-011 SHALL have port MCT_CNT, output, CNT_W: count of completed memory cycles, wrapping modulo 2^CNT_W.
REQ-012 SHALL have port SEQ_ERR, output, 1: one-cycle pulse on an out-of-order timepulse.
REQ-013 SHALL have port MULTI_ERR, output, 1: one-cycle pulse when more than one timepulse is active.
REQ-014 SHALL have port STALL, output, 1: level, high from stall detection until the next valid transition.
REQ-015 SHALL have port ERR_CNT, output, 8: error events, saturating at 255.

Function
REQ-016 SHALL decode active = ~T_n each cycle; cur = index of the single set bit, 0 if none; multi = popcount > 1.
REQ-017 SHALL define a transition as cur != 0, cur != last nonzero index, and multi low. All-inactive gaps between pulses are legal and do not count as a transition.
REQ-018 SHALL register every output, one cycle after the sampled input.
REQ-019 SHALL implement states HUNT, LOCK and FAULT, plus register EXP (expected next index, 1..12).
REQ-020 In HUNT, a transition to 1 SHALL enter LOCK, set EXP=2 and set TP_IDX=1; other transitions SHALL be ignored without error.
REQ-021 In LOCK, a transition equal to EXP SHALL update TP_IDX and advance EXP, wrapping 12 to 1.
REQ-022 In LOCK, a transition 12 to 1 SHALL pulse MCT_STB and increment MCT_CNT.
REQ-023 In LOCK, a transition not equal to EXP SHALL pulse SEQ_ERR, increment ERR_CNT and enter FAULT.
REQ-024 In FAULT, a transition to 1 SHALL return to LOCK with EXP=2, without incrementing MCT_CNT; other transitions SHALL be ignored.
REQ-025 multi high SHALL pulse MULTI_ERR and increment ERR_CNT in any state; in LOCK it SHALL also enter FAULT.
REQ-026 If SEQ_ERR, MULTI_ERR and stall qualify in the same cycle, all qualifying flags SHALL assert but ERR_CNT SHALL increment by exactly 1.
REQ-027 The stall counter SHALL count cycles since the last transition, only while in LOCK with STOP low; it SHALL hold while STOP is high and clear on any transition.
REQ-028 When the stall counter reaches STALL_LIMIT, the block SHALL set STALL, increment ERR_CNT once and enter FAULT.
REQ-029 STALL SHALL clear on the next transition to 1 in FAULT.
REQ-030 While GOJAM is high: state SHALL be forced to HUNT; EXP=1, TP_IDX=0 and STALL=0; the stall counter SHALL clear; no error flag or ERR_CNT increment SHALL occur; MCT_CNT and ERR_CNT SHALL hold.
REQ-031 GOJAM SHALL take precedence over every other event in the same cycle.

Reset
REQ-032 On SIM_RST high at a clock edge: state=HUNT, EXP=1, stall counter=0, TP_IDX=0, LOCKED=0, MCT_STB=0, MCT_CNT=0, SEQ_ERR=0, MULTI_ERR=0, STALL=0, ERR_CNT=0.
REQ-033 Reset SHALL take precedence over GOJAM and all other inputs, and SHALL abort any in-progress sequence.

Structure
REQ-034 Package timer_pkg SHALL hold the state enum (HUNT, LOCK, FAULT), NUM_TP=12 and TP_IDX_W=4.
REQ-035 Sub-module tp_onehot_decode SHALL be purely combinational, mapping T_n to cur and multi.

Verification
REQ-036 Reset, then T01..T12 each 4 cycles with 1-cycle gaps, repeated 3 times -> LOCKED=1 after first T01; MCT_CNT=2; ERR_CNT=0.
REQ-037 Locked at T04, next pulse T06 -> SEQ_ERR one cycle; ERR_CNT=1; LOCKED=0. A later T01 -> LOCKED=1 with MCT_CNT unchanged.
REQ-038 T_n=12'hFF5 (T02 and T04 both active) while LOCK -> MULTI_ERR=1, SEQ_ERR=0, ERR_CNT+1, state FAULT.
REQ-039 STALL_LIMIT=64, locked, inputs frozen at T07 -> STALL rises on cycle 64 and ERR_CNT=1. Same test with STOP high -> no STALL.
REQ-040 GOJAM high mid-sequence at T09 for 10 cycles, then T01 -> TP_IDX=0 and LOCKED=0 during GOJAM; no error flags; relock on T01.
REQ-041 Preload MCT_CNT to 2^CNT_W-1 by running cycles, then complete one more T12 to T01 -> MCT_CNT=0 and MCT_STB=1; force 300 errors -> ERR_CNT=255.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the AGC-style timepulse monitor.
package timer_pkg;

  localparam int NUM_TP   = 12;
  localparam int TP_IDX_W = 4;
  localparam int ERR_W    = 8;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LOCK  = 2'd1,
    FAULT = 2'd2
  } tp_state_e;

  typedef logic [TP_IDX_W-1:0] tp_idx_t;

  // Successor of a timepulse index; T12 wraps back to T01.
  function automatic tp_idx_t nextIdx(input tp_idx_t idx);
    return (idx == tp_idx_t'(NUM_TP)) ? tp_idx_t'(1) : idx + tp_idx_t'(1);
  endfunction

endpackage

// File: rtl/tp_onehot_decode.sv
// Combinational decode of the active-low timepulse bus into an index and a
// more-than-one-active flag.
module tp_onehot_decode
  import timer_pkg::*;
(
  input  logic [NUM_TP-1:0]   T_n,
  output logic [TP_IDX_W-1:0] cur,
  output logic                multi
);

  logic [NUM_TP-1:0]   active;
  logic [TP_IDX_W-1:0] popCnt;
  logic [TP_IDX_W-1:0] lastSet;

  assign active = ~T_n;

  always_comb begin
    popCnt  = '0;
    lastSet = '0;
    for (int i = 0; i < NUM_TP; i++) begin
      if (active[i]) begin
        popCnt  = popCnt + tp_idx_t'(1);
        lastSet = tp_idx_t'(i + 1);
      end
    end
  end

  // A collision reports no index so it can never look like a transition.
  assign multi = (popCnt > tp_idx_t'(1));
  assign cur   = multi ? '0 : lastSet;

endmodule

// File: rtl/timepulse_monitor.sv
// Tracks the T01..T12 timepulse sequence, counts memory cycles and flags
// ordering, collision and stall errors.
module timepulse_monitor
  import timer_pkg::*;
#(
  parameter int STALL_LIMIT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                SIM_CLK,
  input  logic                SIM_RST,
  input  logic [NUM_TP-1:0]   T_n,
  input  logic                GOJAM,
  input  logic                STOP,
  output logic [TP_IDX_W-1:0] TP_IDX,
  output logic                LOCKED,
  output logic                MCT_STB,
  output logic [CNT_W-1:0]    MCT_CNT,
  output logic                SEQ_ERR,
  output logic                MULTI_ERR,
  output logic                STALL,
  output logic [ERR_W-1:0]    ERR_CNT
);

  localparam int SW = $clog2(STALL_LIMIT + 1);

  tp_idx_t   cur;
  logic      multi;

  tp_state_e  state_q;
  tp_idx_t    exp_q;
  tp_idx_t    last_q;
  tp_idx_t    tpIdx_q;
  logic       locked_q;
  logic       mctStb_q;
  logic [CNT_W-1:0] mctCnt_q;
  logic       seqErr_q;
  logic       multiErr_q;
  logic       stall_q;
  logic [ERR_W-1:0] errCnt_q;
  logic [SW-1:0]    stallCnt_q;

  logic [SW-1:0]    stallCnt_d;
  logic [ERR_W-1:0] errCnt_d;
  logic             isTrans;
  logic             stallHit;
  logic             seqHit;
  logic             anyErr;

  tp_onehot_decode u_decode (
    .T_n  (T_n),
    .cur  (cur),
    .multi(multi)
  );

  always_comb begin
    isTrans    = (cur != '0) && (cur != last_q) && !multi;
    stallCnt_d = stallCnt_q + SW'(1);
    stallHit   = (state_q == LOCK) && !STOP && !isTrans &&
                 (stallCnt_d == SW'(STALL_LIMIT));
    seqHit     = (state_q == LOCK) && isTrans && (cur != exp_q);
    anyErr     = seqHit || multi || stallHit;
    errCnt_d   = (errCnt_q == {ERR_W{1'b1}}) ? errCnt_q : errCnt_q + ERR_W'(1);
  end

  // Concurrent error causes in one cycle still cost only one ERR_CNT step.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state_q    <= HUNT;
      exp_q      <= tp_idx_t'(1);
      last_q     <= '0;
      tpIdx_q    <= '0;
      locked_q   <= 1'b0;
      mctStb_q   <= 1'b0;
      mctCnt_q   <= '0;
      seqErr_q   <= 1'b0;
      multiErr_q <= 1'b0;
      stall_q    <= 1'b0;
      errCnt_q   <= '0;
      stallCnt_q <= '0;
    end else begin
      mctStb_q   <= 1'b0;
      seqErr_q   <= 1'b0;
      multiErr_q <= 1'b0;

      if (GOJAM) begin
        state_q    <= HUNT;
        exp_q      <= tp_idx_t'(1);
        last_q     <= '0;
        tpIdx_q    <= '0;
        locked_q   <= 1'b0;
        stall_q    <= 1'b0;
        stallCnt_q <= '0;
      end else begin
        if ((cur != '0) && !multi)
          last_q <= cur;
        if (anyErr)
          errCnt_q <= errCnt_d;
        multiErr_q <= multi;

        case (state_q)
          HUNT: begin
            stallCnt_q <= '0;
            if (isTrans && (cur == tp_idx_t'(1))) begin
              state_q  <= LOCK;
              locked_q <= 1'b1;
              exp_q    <= tp_idx_t'(2);
              tpIdx_q  <= tp_idx_t'(1);
            end
          end

          LOCK: begin
            if (multi || stallHit) begin
              state_q    <= FAULT;
              locked_q   <= 1'b0;
              stallCnt_q <= '0;
              if (stallHit)
                stall_q <= 1'b1;
            end else if (isTrans) begin
              stallCnt_q <= '0;
              if (cur == exp_q) begin
                tpIdx_q <= cur;
                exp_q   <= nextIdx(cur);
                if (cur == tp_idx_t'(1)) begin
                  mctStb_q <= 1'b1;
                  mctCnt_q <= mctCnt_q + CNT_W'(1);
                end
              end else begin
                seqErr_q <= 1'b1;
                state_q  <= FAULT;
                locked_q <= 1'b0;
              end
            end else if (!STOP) begin
              stallCnt_q <= stallCnt_d;
            end
          end

          FAULT: begin
            stallCnt_q <= '0;
            if (isTrans && (cur == tp_idx_t'(1))) begin
              state_q  <= LOCK;
              locked_q <= 1'b1;
              exp_q    <= tp_idx_t'(2);
              tpIdx_q  <= tp_idx_t'(1);
              stall_q  <= 1'b0;
            end
          end

          default: begin
            state_q    <= HUNT;
            locked_q   <= 1'b0;
            exp_q      <= tp_idx_t'(1);
            stallCnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign TP_IDX    = tpIdx_q;
  assign LOCKED    = locked_q;
  assign MCT_STB   = mctStb_q;
  assign MCT_CNT   = mctCnt_q;
  assign SEQ_ERR   = seqErr_q;
  assign MULTI_ERR = multiErr_q;
  assign STALL     = stall_q;
  assign ERR_CNT   = errCnt_q;

endmodule

// File: tb/tb_timepulse_monitor.sv
// Directed self-checking bench for timepulse_monitor (CNT_W shrunk to 4 so
// the memory-cycle counter can be wrapped in a short run).
module tb_timepulse_monitor;

  logic        SIM_CLK = 1'b0;
  logic        SIM_RST;
  logic [11:0] T_n;
  logic        GOJAM;
  logic        STOP;
  logic [3:0]  TP_IDX;
  logic        LOCKED;
  logic        MCT_STB;
  logic [3:0]  MCT_CNT;
  logic        SEQ_ERR;
  logic        MULTI_ERR;
  logic        STALL;
  logic [7:0]  ERR_CNT;

  int checks = 0;
  int errors = 0;

  timepulse_monitor #(.STALL_LIMIT(64), .CNT_W(4)) dut (
    .SIM_CLK  (SIM_CLK),
    .SIM_RST  (SIM_RST),
    .T_n      (T_n),
    .GOJAM    (GOJAM),
    .STOP     (STOP),
    .TP_IDX   (TP_IDX),
    .LOCKED   (LOCKED),
    .MCT_STB  (MCT_STB),
    .MCT_CNT  (MCT_CNT),
    .SEQ_ERR  (SEQ_ERR),
    .MULTI_ERR(MULTI_ERR),
    .STALL    (STALL),
    .ERR_CNT  (ERR_CNT)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  function automatic logic [11:0] tpn(input int i);
    logic [11:0] v;
    v = 12'hFFF;
    if (i >= 1 && i <= 12) v[i-1] = 1'b0;
    return v;
  endfunction

  // Inputs change on the falling edge; outputs are read there too, so each
  // read reflects the last input sampled on the preceding rising edge.
  task automatic applyStimulus(input logic [11:0] tn, input int cycles);
    T_n = tn;
    repeat (cycles) @(negedge SIM_CLK);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    SIM_RST = 1'b1;
    GOJAM   = 1'b0;
    STOP    = 1'b0;
    T_n     = 12'hFFF;
    @(negedge SIM_CLK);
    applyStimulus(12'hFFF, 2);
    SIM_RST = 1'b0;
    checkOutput("rst_tp_idx",  32'(TP_IDX),  0);
    checkOutput("rst_locked",  32'(LOCKED),  0);
    checkOutput("rst_mct_cnt", 32'(MCT_CNT), 0);
    checkOutput("rst_err_cnt", 32'(ERR_CNT), 0);
    checkOutput("rst_stall",   32'(STALL),   0);

    // Three full T01..T12 rounds, 4 cycles per pulse and 1-cycle gaps.
    for (int pass = 0; pass < 3; pass++) begin
      for (int i = 1; i <= 12; i++) begin
        if (i == 1 && pass > 0) begin
          applyStimulus(tpn(1), 1);
          checkOutput("mct_stb_pulse", 32'(MCT_STB), 1);
          applyStimulus(tpn(1), 3);
          checkOutput("mct_stb_clear", 32'(MCT_STB), 0);
        end else begin
          applyStimulus(tpn(i), 4);
        end
        if (pass == 0 && i == 1) begin
          checkOutput("first_lock",   32'(LOCKED), 1);
          checkOutput("first_tp_idx", 32'(TP_IDX), 1);
        end
        applyStimulus(12'hFFF, 1);
      end
    end
    checkOutput("seq_mct_cnt", 32'(MCT_CNT), 2);
    checkOutput("seq_err_cnt", 32'(ERR_CNT), 0);
    checkOutput("seq_tp_idx",  32'(TP_IDX),  12);
    checkOutput("seq_locked",  32'(LOCKED),  1);

    // Out-of-order: T04 followed by T06.
    for (int i = 1; i <= 4; i++) applyStimulus(tpn(i), 2);
    checkOutput("pre_skip_mct", 32'(MCT_CNT), 3);
    applyStimulus(tpn(6), 1);
    checkOutput("skip_seq_err", 32'(SEQ_ERR), 1);
    checkOutput("skip_err_cnt", 32'(ERR_CNT), 1);
    checkOutput("skip_locked",  32'(LOCKED),  0);
    checkOutput("skip_tp_idx",  32'(TP_IDX),  4);
    applyStimulus(tpn(6), 1);
    checkOutput("skip_seq_clr", 32'(SEQ_ERR), 0);
    applyStimulus(tpn(1), 2);
    checkOutput("relock_locked", 32'(LOCKED),  1);
    checkOutput("relock_mct",    32'(MCT_CNT), 3);
    checkOutput("relock_tp_idx", 32'(TP_IDX),  1);

    // Collision of T02 and T04 while locked.
    applyStimulus(tpn(2), 1);
    applyStimulus(12'hFF5, 1);
    checkOutput("multi_flag",    32'(MULTI_ERR), 1);
    checkOutput("multi_seq_err", 32'(SEQ_ERR),   0);
    checkOutput("multi_err_cnt", 32'(ERR_CNT),   2);
    checkOutput("multi_locked",  32'(LOCKED),    0);
    applyStimulus(12'hFFF, 1);
    checkOutput("multi_clr", 32'(MULTI_ERR), 0);
    applyStimulus(tpn(1), 2);
    checkOutput("multi_relock", 32'(LOCKED), 1);

    // Stall: freeze at T07 for exactly STALL_LIMIT cycles.
    for (int i = 2; i <= 7; i++) applyStimulus(tpn(i), 1);
    applyStimulus(tpn(7), 63);
    checkOutput("stall_early",   32'(STALL),  0);
    checkOutput("stall_early_l", 32'(LOCKED), 1);
    applyStimulus(tpn(7), 1);
    checkOutput("stall_rise",    32'(STALL),   1);
    checkOutput("stall_err_cnt", 32'(ERR_CNT), 3);
    checkOutput("stall_locked",  32'(LOCKED),  0);
    applyStimulus(tpn(7), 5);
    checkOutput("stall_hold",     32'(STALL),   1);
    checkOutput("stall_hold_err", 32'(ERR_CNT), 3);
    applyStimulus(tpn(1), 1);
    checkOutput("stall_clear",  32'(STALL),  0);
    checkOutput("stall_relock", 32'(LOCKED), 1);

    // Same freeze with STOP high never stalls.
    for (int i = 2; i <= 6; i++) applyStimulus(tpn(i), 1);
    STOP = 1'b1;
    applyStimulus(tpn(7), 101);
    checkOutput("stop_no_stall", 32'(STALL),   0);
    checkOutput("stop_locked",   32'(LOCKED),  1);
    checkOutput("stop_err_cnt",  32'(ERR_CNT), 3);
    STOP = 1'b0;

    // GOJAM mid-sequence at T09, including a collision that must be ignored.
    applyStimulus(tpn(8), 2);
    applyStimulus(tpn(9), 2);
    checkOutput("pre_gojam_idx", 32'(TP_IDX), 9);
    GOJAM = 1'b1;
    applyStimulus(tpn(9), 1);
    checkOutput("gojam_tp_idx", 32'(TP_IDX), 0);
    checkOutput("gojam_locked", 32'(LOCKED), 0);
    applyStimulus(tpn(9), 4);
    applyStimulus(12'hFF5, 5);
    checkOutput("gojam_multi",   32'(MULTI_ERR), 0);
    checkOutput("gojam_seq",     32'(SEQ_ERR),   0);
    checkOutput("gojam_stall",   32'(STALL),     0);
    checkOutput("gojam_err_cnt", 32'(ERR_CNT),   3);
    checkOutput("gojam_mct_cnt", 32'(MCT_CNT),   3);
    checkOutput("gojam_tp_end",  32'(TP_IDX),    0);
    GOJAM = 1'b0;
    applyStimulus(tpn(1), 2);
    checkOutput("gojam_relock", 32'(LOCKED),  1);
    checkOutput("gojam_tp_one", 32'(TP_IDX),  1);
    checkOutput("gojam_mct",    32'(MCT_CNT), 3);

    // Run twelve more memory cycles to bring MCT_CNT to 15, then wrap it.
    for (int n = 0; n < 12; n++) begin
      for (int i = 2; i <= 12; i++) applyStimulus(tpn(i), 1);
      applyStimulus(tpn(1), 1);
    end
    checkOutput("mct_preload", 32'(MCT_CNT), 15);
    for (int i = 2; i <= 12; i++) applyStimulus(tpn(i), 1);
    applyStimulus(tpn(1), 1);
    checkOutput("mct_wrap",     32'(MCT_CNT), 0);
    checkOutput("mct_wrap_stb", 32'(MCT_STB), 1);

    // 300 collision cycles saturate ERR_CNT.
    applyStimulus(12'hFF5, 300);
    checkOutput("err_saturate",  32'(ERR_CNT),   255);
    checkOutput("err_sat_multi", 32'(MULTI_ERR), 1);
    applyStimulus(12'hFFF, 1);
    applyStimulus(12'hFF5, 1);
    checkOutput("err_sat_hold", 32'(ERR_CNT), 255);

    // Reset wins over a simultaneous GOJAM and a valid T01.
    SIM_RST = 1'b1;
    GOJAM   = 1'b1;
    applyStimulus(tpn(1), 1);
    checkOutput("rst2_err_cnt", 32'(ERR_CNT), 0);
    checkOutput("rst2_mct_cnt", 32'(MCT_CNT), 0);
    checkOutput("rst2_locked",  32'(LOCKED),  0);
    checkOutput("rst2_tp_idx",  32'(TP_IDX),  0);
    SIM_RST = 1'b0;
    GOJAM   = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
